// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared constants and state encoding for the rvseed fetch sequencer.
package fetch_seq_ctrl_pkg;

  localparam int unsigned DEF_CPU_WIDTH = 32;
  localparam logic [31:0] DEF_RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] DEF_NOP_INST  = 32'h0000_0013;

  // Fetch sequencer states; encodings are shared with the core defines.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_seq_ctrl.sv
// Stall-aware instruction fetch sequencer: owns the fetch PC, runs a single
// outstanding imem request/response, and holds the fetched word for decode.
module fetch_seq_ctrl
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int unsigned           CPU_WIDTH = DEF_CPU_WIDTH,
  parameter logic [CPU_WIDTH-1:0]  RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0]           NOP_INST  = DEF_NOP_INST
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [CPU_WIDTH-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  output logic                 inst_valid,
  output logic [31:0]          inst,
  output logic [CPU_WIDTH-1:0] inst_pc,
  input  logic                 inst_ready,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc
);

  fetch_state_t         state;
  logic [CPU_WIDTH-1:0] pc;
  logic                 discard;
  logic [CPU_WIDTH-1:0] target_pc;
  logic [1:0]           unused_redirect_lsb;

  // Redirect targets are always word aligned; the low bits are dropped.
  assign target_pc           = {redirect_pc[CPU_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsb = redirect_pc[1:0];

  // Request and address are pure decodes of registered state.
  assign imem_req  = (state == ST_REQ);
  assign imem_addr = pc;

  // Sequencer: state, PC, squash flag and the held instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      pc         <= RESET_PC;
      discard    <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= NOP_INST;
      inst_pc    <= RESET_PC;
    end else begin
      case (state)
        ST_BOOT: begin
          if (redirect_valid) pc <= target_pc;
          state <= ST_REQ;
        end

        ST_REQ: begin
          if (imem_gnt) begin
            // A redirect racing the grant marks the response as stale.
            discard <= redirect_valid;
            if (redirect_valid) pc <= target_pc;
            state <= ST_WAIT;
          end else if (redirect_valid) begin
            pc <= target_pc;
          end
        end

        ST_WAIT: begin
          if (imem_rvalid) begin
            if (discard || redirect_valid) begin
              discard <= 1'b0;
              if (redirect_valid) pc <= target_pc;
              state <= ST_REQ;
            end else begin
              inst       <= imem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc + CPU_WIDTH'(4);
              state      <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            discard <= 1'b1;
            pc      <= target_pc;
          end
        end

        ST_HOLD: begin
          if (redirect_valid || inst_ready) begin
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            if (redirect_valid) pc <= target_pc;
            state <= ST_REQ;
          end
        end

        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule
